// File: rtl/vote_result_reader.sv
// ----------------------------------------------------------------------------
// vote_result_reader
//
// Purpose:
//   After voting closes (mode=1), a start request takes a snapshot of the four
//   live candidate tallies. The block then presents one record per candidate,
//   in order 1..4, over a valid/ready handshake. When all four records have
//   been accepted, it spends one cycle resolving the winner and tie flag from
//   the snapshot. It then pulses done for one cycle.
//
// Ports:
//   clk                      rising-edge clock
//   reset                    synchronous, active-high reset
//   mode                     0 = voting, 1 = result (readout runs only while 1)
//   start                    readout request, honoured in IDLE with mode=1
//   can_recev_1..4 [CNT_W]   live tallies from the vote counter
//   out_ready                downstream accepts the presented record
//   out_valid                a record is presented
//   out_id [3]               candidate 1..4 of the record, 0 when idle
//   out_count [CNT_W]        snapshot tally of candidate out_id
//   busy                     readout in progress (SEND / RESOLVE)
//   done                     one-cycle completion pulse
//   winner [3]               lowest-numbered candidate with the max tally,
//                            0 when no votes were cast
//   tie                      max non-zero tally held by more than one candidate
// ----------------------------------------------------------------------------
module vote_result_reader #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mode,
   input  logic             start,
   input  logic [CNT_W-1:0] can_recev_1,
   input  logic [CNT_W-1:0] can_recev_2,
   input  logic [CNT_W-1:0] can_recev_3,
   input  logic [CNT_W-1:0] can_recev_4,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [2:0]       out_id,
   output logic [CNT_W-1:0] out_count,
   output logic             busy,
   output logic             done,
   output logic [2:0]       winner,
   output logic             tie
);

   localparam int NUM_CAND = 4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SEND    = 2'd1,
      S_RESOLVE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t                           state_q, state_d;
   logic [2:0]                       idx_q, idx_d;
   logic [NUM_CAND-1:0][CNT_W-1:0]   snap_q, snap_d;
   logic [2:0]                       winner_q, winner_d;
   logic                             tie_q, tie_d;

   // Winner/tie evaluation over the snapshot only; live tallies never reach it.
   logic [CNT_W-1:0]                 max_v;
   logic [2:0]                       best_id;
   logic [2:0]                       n_max;
   logic [2:0]                       res_winner;
   logic                             res_tie;

   always_comb begin
      max_v   = snap_q[0];
      best_id = 3'd1;
      // Strict '>' keeps the lowest-numbered candidate on equal tallies.
      for (int i = 1; i < NUM_CAND; i++) begin
         if (snap_q[i] > max_v) begin
            max_v   = snap_q[i];
            best_id = 3'(i + 1);
         end
      end
      n_max = 3'd0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (snap_q[i] == max_v) n_max = n_max + 3'd1;
      end
      if (max_v == '0) begin
         res_winner = 3'd0;
         res_tie    = 1'b0;
      end else begin
         res_winner = best_id;
         res_tie    = (n_max > 3'd1);
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      snap_d   = snap_q;
      winner_d = winner_q;
      tie_d    = tie_q;

      unique case (state_q)
         S_IDLE: begin
            if (start && mode) begin
               snap_d  = {can_recev_4, can_recev_3, can_recev_2, can_recev_1};
               idx_d   = 3'd1;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            // Leaving result mode aborts immediately, even if a record is
            // being accepted on this same edge.
            if (!mode) begin
               idx_d   = 3'd0;
               state_d = S_IDLE;
            end else if (out_ready) begin
               if (idx_q == 3'd4) begin
                  idx_d   = 3'd0;
                  state_d = S_RESOLVE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         S_RESOLVE: begin
            // An abort here must leave the previous result untouched.
            if (!mode) begin
               state_d = S_IDLE;
            end else begin
               winner_d = res_winner;
               tie_d    = res_tie;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= 3'd0;
         snap_q   <= '0;
         winner_q <= 3'd0;
         tie_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         snap_q   <= snap_d;
         winner_q <= winner_d;
         tie_q    <= tie_d;
      end
   end

   // Outputs are decoded from registered state only, so out_valid has no
   // combinational path from out_ready.
   logic [1:0] rec_sel;
   assign rec_sel = 2'(idx_q - 3'd1);

   always_comb begin
      out_valid = 1'b0;
      out_id    = 3'd0;
      out_count = '0;
      if (state_q == S_SEND) begin
         out_valid = 1'b1;
         out_id    = idx_q;
         out_count = snap_q[rec_sel];
      end
   end

   assign busy   = (state_q == S_SEND) || (state_q == S_RESOLVE);
   assign done   = (state_q == S_DONE);
   assign winner = winner_q;
   assign tie    = tie_q;

endmodule

// File: tb/tb_vote_result_reader.sv
module tb_vote_result_reader;

   logic       clk = 1'b0;
   logic       reset, mode, start, out_ready;
   logic [7:0] c1, c2, c3, c4;
   logic       out_valid, busy, done, tie;
   logic [2:0] out_id, winner;
   logic [7:0] out_count;

   vote_result_reader #(.CNT_W(8)) dut (
      .clk(clk), .reset(reset), .mode(mode), .start(start),
      .can_recev_1(c1), .can_recev_2(c2), .can_recev_3(c3), .can_recev_4(c4),
      .out_ready(out_ready), .out_valid(out_valid), .out_id(out_id),
      .out_count(out_count), .busy(busy), .done(done),
      .winner(winner), .tie(tie)
   );

   always #5 clk = ~clk;

   int errs   = 0;
   int checks = 0;

   typedef struct {
      logic [2:0] id;
      logic [7:0] cnt;
   } rec_t;
   rec_t sb[$];

   logic [2:0] prev_win;
   logic       prev_tie;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1; mode = 0; start = 0; out_ready = 0;
      c1 = 0; c2 = 0; c3 = 0; c4 = 0;
      tick(); tick();
      reset = 0;
      checks++;
      if ({out_valid, out_id, out_count, busy, done, winner, tie} !== 16'd0) begin
         errs++;
         $display("FAIL reset_outputs: got v=%b id=%0d cnt=%0d busy=%b done=%b win=%0d tie=%b, want all 0",
                  out_valid, out_id, out_count, busy, done, winner, tie);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL reset_idle_hold: got v=%b busy=%b, want 0 0", out_valid, busy);
      end
      prev_win = 3'd0;
      prev_tie = 1'b0;
   endtask

   task automatic readout(input string nm, input logic [7:0] a, b, c, d,
                          input int rdy_toggle, input logic [7:0] a_after,
                          input logic [2:0] ew, input logic ewt);
      int   first_valid;
      bit   fin;
      rec_t r;
      c1 = a; c2 = b; c3 = c; c4 = d;
      sb.delete();
      r.id = 3'd1; r.cnt = a; sb.push_back(r);
      r.id = 3'd2; r.cnt = b; sb.push_back(r);
      r.id = 3'd3; r.cnt = c; sb.push_back(r);
      r.id = 3'd4; r.cnt = d; sb.push_back(r);
      mode = 1; start = 1; out_ready = 0;
      tick();
      start = 0;
      c1 = a_after;
      first_valid = -1;
      fin = 0;
      for (int k = 1; k <= 40 && !fin; k++) begin
         if (out_valid) begin
            if (first_valid < 0) first_valid = k;
            checks++;
            if (sb.size() == 0) begin
               errs++;
               $display("FAIL %s_extra_record: got id=%0d cnt=%0d, want none", nm, out_id, out_count);
            end else if (out_id !== sb[0].id || out_count !== sb[0].cnt) begin
               errs++;
               $display("FAIL %s_record: got (%0d,%0d), want (%0d,%0d)",
                        nm, out_id, out_count, sb[0].id, sb[0].cnt);
            end
            checks++;
            if (busy !== 1'b1 || winner !== prev_win || tie !== prev_tie) begin
               errs++;
               $display("FAIL %s_send_status: got busy=%b win=%0d tie=%b, want 1 %0d %b",
                        nm, busy, winner, tie, prev_win, prev_tie);
            end
         end
         if (done) begin
            checks++;
            if (sb.size() != 0) begin
               errs++;
               $display("FAIL %s_records_left: got %0d undelivered, want 0", nm, sb.size());
            end
            checks++;
            if (winner !== ew || tie !== ewt) begin
               errs++;
               $display("FAIL %s_result: got win=%0d tie=%b, want %0d %b", nm, winner, tie, ew, ewt);
            end
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
               errs++;
               $display("FAIL %s_done_status: got busy=%b v=%b, want 0 0", nm, busy, out_valid);
            end
            if (rdy_toggle == 0) begin
               checks++;
               if (k != 6) begin
                  errs++;
                  $display("FAIL %s_done_latency: got %0d, want 6", nm, k);
               end
            end
            fin = 1;
         end
         out_ready = (rdy_toggle == 0) ? 1'b1 : ((k % 2) == 0);
         if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
         tick();
      end
      checks++;
      if (!fin) begin
         errs++;
         $display("FAIL %s_timeout: got no done in 40 cycles, want done", nm);
      end
      checks++;
      if (first_valid != 1) begin
         errs++;
         $display("FAIL %s_first_valid: got %0d, want 1", nm, first_valid);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL %s_after_done: got done=%b busy=%b, want 0 0", nm, done, busy);
      end
      out_ready = 0;
      prev_win = ew;
      prev_tie = ewt;
   endtask

   task automatic test_mode0_start();
      c1 = 5; c2 = 6; c3 = 7; c4 = 8;
      mode = 0; start = 1; out_ready = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL mode0_start: got v=%b busy=%b done=%b, want 0 0 0", out_valid, busy, done);
         end
      end
      start = 0; out_ready = 0;
   endtask

   task automatic test_abort();
      c1 = 1; c2 = 2; c3 = 3; c4 = 4;
      mode = 1; start = 1; out_ready = 0;
      tick();
      start = 0; out_ready = 1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_id !== 3'd2 || out_count !== 8'd2) begin
         errs++;
         $display("FAIL abort_pre: got v=%b id=%0d cnt=%0d, want 1 2 2", out_valid, out_id, out_count);
      end
      mode = 0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_id !== 3'd0) begin
         errs++;
         $display("FAIL abort_now: got v=%b busy=%b id=%0d, want 0 0 0", out_valid, busy, out_id);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (done !== 1'b0 || winner !== prev_win || tie !== prev_tie) begin
            errs++;
            $display("FAIL abort_hold: got done=%b win=%0d tie=%b, want 0 %0d %b",
                     done, winner, tie, prev_win, prev_tie);
         end
         tick();
      end
      out_ready = 0;
   endtask

   task automatic test_reset_mid();
      c1 = 9; c2 = 8; c3 = 7; c4 = 6;
      mode = 1; start = 1; out_ready = 1;
      tick();
      start = 0;
      tick();
      reset = 1;
      tick();
      checks++;
      if ({out_valid, out_id, out_count, busy, done, winner, tie} !== 16'd0) begin
         errs++;
         $display("FAIL reset_mid: got v=%b id=%0d cnt=%0d busy=%b done=%b win=%0d tie=%b, want all 0",
                  out_valid, out_id, out_count, busy, done, winner, tie);
      end
      reset = 0; out_ready = 0;
      prev_win = 3'd0;
      prev_tie = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      readout("basic",    8'd3,   8'd7, 8'd2, 8'd5,   0, 8'd3,   3'd2, 1'b0);
      readout("toggle",   8'd4,   8'd9, 8'd9, 8'd1,   1, 8'd4,   3'd2, 1'b1);
      readout("allzero",  8'd0,   8'd0, 8'd0, 8'd0,   0, 8'd0,   3'd0, 1'b0);
      readout("maxtie",   8'd255, 8'd0, 8'd0, 8'd255, 0, 8'd255, 3'd1, 1'b1);
      readout("last",     8'd0,   8'd0, 8'd0, 8'd1,   1, 8'd0,   3'd4, 1'b0);
      test_mode0_start();
      readout("snapshot", 8'd3,   8'd1, 8'd1, 8'd1,   0, 8'd8,   3'd1, 1'b0);
      test_abort();
      test_reset_mid();
      readout("postrst",  8'd3,   8'd7, 8'd2, 8'd5,   0, 8'd3,   3'd2, 1'b0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/vote_result_reader.md
VOTE_RESULT_READER -- requirements
Module: vote_result_reader

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of each candidate tally.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: mode  input  1  0 = voting, 1 = result; readout runs only while 1.
REQ-005 SHALL have port: start  input  1  request to begin a readout; sampled each cycle.
REQ-006 SHALL have ports: can_recev_1..can_recev_4  input  CNT_W each  live tallies from the vote counter.
REQ-007 SHALL have port: out_ready  input  1  downstream (display/serialiser) accepts the current record.
REQ-008 SHALL have port: out_valid  output  1  a record is presented.
REQ-009 SHALL have port: out_id  output  3  candidate number 1..4 of the presented record; 0 when idle.
REQ-010 SHALL have port: out_count  output  CNT_W  tally of candidate out_id.
REQ-011 SHALL have port: busy  output  1  readout in progress.
REQ-012 SHALL have port: done  output  1  one-cycle pulse when the readout completes.
REQ-013 SHALL have port: winner  output  3  candidate with the highest tally; 0 = no votes cast.
REQ-014 SHALL have port: tie  output  1  two or more candidates share the highest non-zero tally.

Function
REQ-015 SHALL implement states IDLE, SEND, RESOLVE, DONE.
REQ-016 In IDLE, start=1 and mode=1 at a clock edge SHALL snapshot all four tallies, set index=1, enter SEND, assert busy from the next cycle.
REQ-017 start while mode=0 SHALL be ignored; start while not in IDLE SHALL be ignored.
REQ-018 In SEND, out_valid=1, out_id=index, out_count=snapshot[index]; values SHALL stay stable until accepted.
REQ-019 A record SHALL be accepted on a clock edge where out_valid=1 and out_ready=1; out_valid SHALL NOT depend combinationally on out_ready.
REQ-020 On acceptance with index<4, index SHALL increment and the next record SHALL be presented on the following cycle (back-to-back, one record per cycle when out_ready held 1).
REQ-021 On acceptance of index=4, SHALL enter RESOLVE; out_valid=0, out_id=0.
REQ-022 RESOLVE SHALL last exactly one cycle, computing winner/tie from the snapshot only, registered at its end.
REQ-023 winner SHALL be the lowest-numbered candidate holding the maximum tally; tie=1 iff that maximum is shared by another candidate.
REQ-024 If all four snapshot tallies are 0, winner SHALL be 0 and tie SHALL be 0.
REQ-025 Comparison SHALL be unsigned over full CNT_W; max value (255 at default) SHALL compare correctly.
REQ-026 DONE SHALL last one cycle with done=1, busy=0 in that cycle, then return to IDLE.
REQ-027 winner and tie SHALL hold until the next RESOLVE or reset; not cleared on new start.
REQ-028 Changes on can_recev_* after the snapshot SHALL NOT affect out_count, winner or tie of the current readout.
REQ-029 mode falling to 0 in SEND or RESOLVE SHALL abort to IDLE on that edge: out_valid=0, busy=0, no done pulse, winner/tie unchanged.
REQ-030 Latency: start edge to first out_valid = 1 cycle; with out_ready held 1, start edge to done = 6 cycles.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE from any state, overriding start and handshake.
REQ-032 After reset: out_valid=0, out_id=0, out_count=0, busy=0, done=0, winner=0, tie=0, snapshot and index cleared.

Verification
REQ-033 Tallies 3,7,2,5, mode=1, start pulse, out_ready=1 -> records (1,3),(2,7),(3,2),(4,5) on consecutive cycles, done 2 cycles after last, winner=2, tie=0.
REQ-034 Tallies 4,9,9,1, out_ready toggling 1/0 -> each record held stable while out_ready=0, all four delivered once in order, winner=2, tie=1.
REQ-035 Tallies all 0 -> four records of count 0, winner=0, tie=0; tallies 255,0,0,255 -> winner=1, tie=1.
REQ-036 start with mode=0 -> no out_valid, busy stays 0; can_recev_1 changed 3->8 during SEND -> record 1 still reports 3.
REQ-037 mode dropped to 0 while presenting record 2 -> out_valid=0 and busy=0 next cycle, no done, prior winner retained.
REQ-038 reset asserted mid-SEND -> next cycle all outputs 0, state IDLE; subsequent start works normally.
